// File: rtl/divisor_secuencial_if.sv
// Start/busy/done handshake and operand/result bus of the sequential divider.
// The ALU control FSM drives the master side; the divider implements the slave side.
interface divisor_secuencial_if #(
    parameter int N = 4
);
    logic         start_i;
    logic [N-1:0] dividendo_i;
    logic [N-1:0] divisor_i;
    logic [N-1:0] cociente_o;
    logic [N-1:0] residuo_o;
    logic         div_cero_o;
    logic         busy_o;
    logic         done_o;

    modport master (
        output start_i, dividendo_i, divisor_i,
        input  cociente_o, residuo_o, div_cero_o, busy_o, done_o
    );

    modport slave (
        input  start_i, dividendo_i, divisor_i,
        output cociente_o, residuo_o, div_cero_o, busy_o, done_o
    );
endinterface

// File: rtl/divisor_secuencial.sv
// Unsigned restoring divider: one quotient bit per clock from an (N+1)-bit trial
// subtraction done as an add of the negated divisor (carry-out = 1 means no borrow).
module divisor_secuencial #(
    parameter int N = 4
) (
    input logic                clk_i,
    input logic                rst_n_i,
    divisor_secuencial_if.slave bus
);

    localparam int CW = (N > 2) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  d_q, d_d;
    logic [N-1:0]  q_q, q_d;
    logic [N:0]    r_q, r_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  cociente_q, cociente_d;
    logic [N-1:0]  residuo_q, residuo_d;
    logic          div_cero_q, div_cero_d;

    logic          accept;
    logic          divisor_cero;
    logic [N:0]    rs;
    logic [N:0]    neg_d;
    logic [N+1:0]  trial;
    logic          qbit;
    logic [N:0]    r_next;
    logic [N-1:0]  q_next;
    logic          r_msb_unused;

    // A request is only seen while no division is in flight; DONE accepts back-to-back.
    assign accept       = bus.start_i && (state_q != RUN);
    assign divisor_cero = (bus.divisor_i == '0);

    // The partial remainder never reaches D, so its top bit is never shifted back in.
    assign r_msb_unused = r_q[N];

    // Trial subtraction, same structure as the ALU subtractor stage.
    always_comb begin
        rs     = {r_q[N-1:0], q_q[N-1]};
        neg_d  = ~{1'b0, d_q} + (N+1)'(1);
        trial  = {1'b0, rs} + {1'b0, neg_d};
        qbit   = trial[N+1];
        r_next = qbit ? trial[N:0] : rs;
        q_next = {q_q[N-2:0], qbit};
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start_i) begin
                    state_d = divisor_cero ? DONE : RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.busy_o = (state_q == RUN);
        bus.done_o = (state_q == DONE);
    end

    always_comb begin
        d_d        = d_q;
        q_d        = q_q;
        r_d        = r_q;
        cnt_d      = cnt_q;
        cociente_d = cociente_q;
        residuo_d  = residuo_q;
        div_cero_d = div_cero_q;
        if (accept) begin
            d_d        = bus.divisor_i;
            q_d        = bus.dividendo_i;
            r_d        = '0;
            cnt_d      = CW'(N - 1);
            div_cero_d = 1'b0;
            // Division by zero skips RUN and reports straight away.
            if (divisor_cero) begin
                cociente_d = '1;
                residuo_d  = bus.dividendo_i;
                div_cero_d = 1'b1;
            end
        end else if (state_q == RUN) begin
            q_d   = q_next;
            r_d   = r_next;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == '0) begin
                cociente_d = q_next;
                residuo_d  = r_next[N-1:0];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            d_q        <= '0;
            q_q        <= '0;
            r_q        <= '0;
            cnt_q      <= '0;
            cociente_q <= '0;
            residuo_q  <= '0;
            div_cero_q <= 1'b0;
        end else begin
            d_q        <= d_d;
            q_q        <= q_d;
            r_q        <= r_d;
            cnt_q      <= cnt_d;
            cociente_q <= cociente_d;
            residuo_q  <= residuo_d;
            div_cero_q <= div_cero_d;
        end
    end

    assign bus.cociente_o = cociente_q;
    assign bus.residuo_o  = residuo_q;
    assign bus.div_cero_o = div_cero_q;

endmodule

// File: tb/tb_divisor_secuencial.sv
// Directed and randomized bench for divisor_secuencial at N=4 and N=8, checked
// against plain integer division and the quotient/remainder invariant.
module tb_divisor_secuencial;

    logic clk = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   errors  = 0;

    always #5 clk = ~clk;

    divisor_secuencial_if #(.N(4)) if4 ();
    divisor_secuencial_if #(.N(8)) if8 ();

    divisor_secuencial #(.N(4)) dut4 (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (if4)
    );

    divisor_secuencial #(.N(8)) dut8 (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (if8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic start4(input int a, input int b);
        if4.dividendo_i = 4'(a);
        if4.divisor_i   = 4'(b);
        if4.start_i     = 1'b1;
        tick();
        if4.start_i     = 1'b0;
    endtask

    task automatic start8(input int a, input int b);
        if8.dividendo_i = 8'(a);
        if8.divisor_i   = 8'(b);
        if8.start_i     = 1'b1;
        tick();
        if8.start_i     = 1'b0;
    endtask

    // Called in the cycle after the start edge; returns in the done_o cycle.
    task automatic wait4(input int a, input int b, input bit glitch, input string tag);
        int lat = 1;
        int bc  = 0;
        while (if4.done_o !== 1'b1 && lat < 40) begin
            if (if4.busy_o === 1'b1) bc++;
            if4.start_i = glitch && (if4.busy_o === 1'b1);
            if (glitch) begin
                if4.dividendo_i = 4'($urandom);
                if4.divisor_i   = 4'($urandom);
            end
            tick();
            lat++;
        end
        if4.start_i = 1'b0;
        chk({tag, " latency"}, lat, (b == 0) ? 1 : 5);
        chk({tag, " busy_cycles"}, bc, (b == 0) ? 0 : 4);
        chk({tag, " busy_at_done"}, if4.busy_o, 0);
        chk({tag, " cociente"}, if4.cociente_o, (b == 0) ? 15 : a / b);
        chk({tag, " residuo"}, if4.residuo_o, (b == 0) ? a : a % b);
        chk({tag, " div_cero"}, if4.div_cero_o, (b == 0) ? 1 : 0);
    endtask

    task automatic wait8(input int a, input int b, input string tag);
        int lat = 1;
        int bc  = 0;
        while (if8.done_o !== 1'b1 && lat < 40) begin
            if (if8.busy_o === 1'b1) bc++;
            tick();
            lat++;
        end
        chk({tag, " latency"}, lat, (b == 0) ? 1 : 9);
        chk({tag, " busy_cycles"}, bc, (b == 0) ? 0 : 8);
        chk({tag, " cociente"}, if8.cociente_o, (b == 0) ? 255 : a / b);
        chk({tag, " residuo"}, if8.residuo_o, (b == 0) ? a : a % b);
        chk({tag, " div_cero"}, if8.div_cero_o, (b == 0) ? 1 : 0);
        if (b != 0) begin
            chk({tag, " invariant"}, int'(if8.cociente_o) * b + int'(if8.residuo_o), a);
            chk({tag, " rem_lt_div"}, (int'(if8.residuo_o) < b) ? 1 : 0, 1);
        end
    endtask

    task automatic after_done4(input int q, input string tag);
        tick();
        chk({tag, " done_single"}, if4.done_o, 0);
        chk({tag, " hold"}, if4.cociente_o, q);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        int a;
        int b;
        rst_n           = 1'b0;
        if4.start_i     = 1'b0;
        if4.dividendo_i = '0;
        if4.divisor_i   = '0;
        if8.start_i     = 1'b0;
        if8.dividendo_i = '0;
        if8.divisor_i   = '0;
        tick();
        tick();
        rst_n = 1'b1;
        chk("reset cociente", if4.cociente_o, 0);
        chk("reset residuo", if4.residuo_o, 0);
        chk("reset div_cero", if4.div_cero_o, 0);
        chk("reset busy", if4.busy_o, 0);
        chk("reset done", if4.done_o, 0);
        chk("reset8 done", if8.done_o, 0);

        start4(13, 3);
        wait4(13, 3, 1'b0, "13/3");
        after_done4(4, "13/3");

        start4(15, 1);  wait4(15, 1, 1'b0, "15/1");
        start4(3, 9);   wait4(3, 9, 1'b0, "3/9");
        start4(15, 15); wait4(15, 15, 1'b0, "15/15");
        start4(0, 5);   wait4(0, 5, 1'b0, "0/5");
        after_done4(0, "0/5");

        start4(7, 0);
        wait4(7, 0, 1'b0, "7/0");
        after_done4(15, "7/0");
        start4(8, 2);
        wait4(8, 2, 1'b0, "8/2");
        after_done4(4, "8/2");

        start4(14, 4);
        wait4(14, 4, 1'b1, "14/4 ignore");
        after_done4(3, "14/4 ignore");

        // Abort in the second RUN cycle.
        start4(12, 5);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort cociente", if4.cociente_o, 0);
        chk("abort residuo", if4.residuo_o, 0);
        chk("abort div_cero", if4.div_cero_o, 0);
        chk("abort busy", if4.busy_o, 0);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (if4.done_o === 1'b1) pulses++;
            tick();
        end
        chk("abort done_pulses", pulses, 0);
        start4(10, 3);
        wait4(10, 3, 1'b0, "10/3");

        start8(200, 7);
        wait8(200, 7, "200/7");
        start8(255, 16);
        chk("b2b busy", if8.busy_o, 1);
        wait8(255, 16, "255/16");
        tick();

        for (int i = 0; i < 24; i++) begin
            a = int'($urandom_range(0, 255));
            b = (i == 5) ? 0 : int'($urandom_range(0, 255));
            start8(a, b);
            wait8(a, b, "rand8");
        end
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/divisor_secuencial.md
Name: divisor_secuencial

Overview:
- Unsigned sequential restoring divider for the ALU. Produces one quotient bit per clock from an (N+1)-bit trial subtraction.
- Each trial subtraction is built exactly as in the ALU subtractor stage: two's-complement add of the negated divisor, with carry-out = 1 meaning "no borrow".
- Sits downstream of the subtractor, feeding the ALU result mux. Uses a start/busy/done handshake so the ALU control FSM can issue one division at a time.

Parameters:
- N, 4, operand width in bits for dividend, divisor, quotient and remainder (N >= 2).

Ports:
- clk_i  input  1  single clock; all state updates on rising edge.
- rst_n_i  input  1  synchronous reset, active low.
- start_i  input  1  request a division; sampled only when busy_o = 0.
- dividendo_i  input  N  unsigned dividend; captured with start_i.
- divisor_i  input  N  unsigned divisor; captured with start_i.
- cociente_o  output  N  quotient; valid from done_o until the next accepted start.
- residuo_o  output  N  remainder; valid from done_o until the next accepted start.
- div_cero_o  output  1  divisor was zero for the last completed operation.
- busy_o  output  1  high while a division is in progress (state RUN).
- done_o  output  1  one-cycle pulse when results become valid.

Behaviour:
- Reset (rst_n_i = 0 at a rising edge):
  - state = IDLE; cociente_o, residuo_o, div_cero_o, busy_o, done_o = 0.
  - All internal registers and the counter are cleared.
  - Reset overrides start_i. Reset during RUN aborts the operation with no done_o pulse.
- States: IDLE, RUN, DONE.
- IDLE or DONE with start_i = 1 (accept):
  - Latch D = divisor_i and Q = dividendo_i; clear partial remainder R (N+1 bits); cnt = N-1; clear div_cero_o.
  - divisor_i != 0: next state RUN, busy_o = 1 from the next cycle.
  - divisor_i == 0: next state DONE directly. cociente_o = all ones, residuo_o = dividendo_i, div_cero_o = 1, done_o = 1 for exactly the next cycle. No RUN cycles.
- IDLE with start_i = 0: hold. Outputs keep their last values.
- RUN, one iteration per edge:
  - Rs = {R[N-1:0], Q[N-1]}.
  - T = Rs + (~{0,D} + 1), computed in N+2 bits; carry = bit N+1.
  - carry = 1 (Rs >= D): R = T[N:0], new quotient LSB = 1.
  - carry = 0: R = Rs, new quotient LSB = 0.
  - Q = {Q[N-2:0], qbit}; cnt decrements.
  - Iteration with cnt == 0: load cociente_o = final Q and residuo_o = final R[N-1:0]; next state DONE.
- DONE: done_o = 1 for this single cycle; next state IDLE unless a start is accepted (back-to-back allowed).
- Latency: start accepted at edge 0. Valid operands give N RUN edges; done_o is high in the cycle after edge N. Divide-by-zero: done_o is high in the cycle after edge 0.
- start_i while busy_o = 1: ignored. Operand inputs may change freely during RUN.
- busy_o and done_o are never high in the same cycle.
- Arithmetic invariant, checked at every done_o with div_cero_o = 0: dividendo = cociente*divisor + residuo, residuo < divisor.
- Result outputs change only on an accepted start or at the RUN-to-DONE transition; they hold otherwise, including in IDLE.

Test Plan:
- N=4, reset, then start with 13/3 → busy_o high 4 cycles; done_o high exactly in the 5th cycle after the start edge; cociente_o = 4, residuo_o = 1, div_cero_o = 0.
- N=4, boundaries: 15/1 → 15 r 0; 3/9 → 0 r 3; 15/15 → 1 r 0; 0/5 → 0 r 0. Each has latency N+1 to done_o.
- N=4, 7/0 → busy_o never asserted; done_o high in the cycle after the start edge; cociente_o = 15, residuo_o = 7, div_cero_o = 1. A following 8/2 clears div_cero_o → 4 r 0.
- N=4, start 14/4, then pulse start_i with 9/3 and change operand inputs during RUN → second request ignored; result 3 r 2.
- N=4, rst_n_i low for one cycle during the 2nd RUN cycle → all outputs 0 on the next cycle; no done_o pulse; a fresh start with 10/3 then gives 3 r 1.
- N=8, start 200/7 asserted again in the DONE cycle with 255/16 → first result 28 r 4, then immediately RUN again, 15 r 15. Randomized 8-bit operands are checked against the arithmetic invariant.
